mood_classifier: RTL

- Sits directly downstream of the mood saturating counter and consumes its N-bit `value`.
- Quantises `value` into three mood levels (SAD, NEUTRAL, HAPPY).
- Uses threshold hysteresis plus a minimum dwell time, so counter jitter cannot cause output chatter.
- Drives the display/actuator logic with a stable mood code and a one-cycle change pulse.

---
 rtl/moody_pkg.sv | 15 +
 rtl/mood_classifier_dwell_timer.sv | 32 +++
 rtl/mood_classifier.sv | 119 +++++++++++
 3 files changed

// File: rtl/moody_pkg.sv
// rtl/moody_pkg.sv - shared mood encodings and default thresholds
package moody_pkg;

  localparam logic [1:0] MOOD_SAD     = 2'b00;
  localparam logic [1:0] MOOD_NEUTRAL = 2'b01;
  localparam logic [1:0] MOOD_HAPPY   = 2'b10;

  localparam int DEF_N       = 8;
  localparam int DEF_T_LOW   = 64;
  localparam int DEF_T_HIGH  = 192;
  localparam int DEF_HYST    = 8;
  localparam int DEF_DWELL_W = 4;
  localparam int DEF_DWELL   = 10;

endpackage

// File: rtl/mood_classifier_dwell_timer.sv
// rtl/mood_classifier_dwell_timer.sv - tick-qualified dwell counter with restart and hold
module dwell_timer #(
  parameter int DWELL_W = 4,
  parameter int DWELL   = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic tick,
  output logic done
);

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

  if (DWELL < 1 || DWELL > (2 ** DWELL_W) - 1) begin : g_bad_dwell
    $fatal(1, "dwell_timer: DWELL must be within 1..2^DWELL_W-1");
  end

  logic [DWELL_W-1:0] count;

  // restart wins over a tick landing on the terminal count
  assign done = tick && !restart && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || restart || done) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mood_classifier.sv
// rtl/mood_classifier.sv - hysteretic, dwell-filtered three-level mood quantiser
module mood_classifier
  import moody_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int T_LOW   = DEF_T_LOW,
  parameter int T_HIGH  = DEF_T_HIGH,
  parameter int HYST    = DEF_HYST,
  parameter int DWELL_W = DEF_DWELL_W,
  parameter int DWELL   = DEF_DWELL
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] value,
  input  logic         tick,
  output logic [1:0]   mood,
  output logic         mood_changed,
  output logic         mood_up,
  output logic         pending
);

  if (HYST > T_LOW) begin : g_bad_hyst
    $fatal(1, "mood_classifier: HYST must not exceed T_LOW");
  end
  if (T_LOW + HYST >= T_HIGH - HYST) begin : g_bad_band
    $fatal(1, "mood_classifier: hysteresis bands overlap");
  end
  if (T_HIGH + HYST > (2 ** N) - 1) begin : g_bad_top
    $fatal(1, "mood_classifier: T_HIGH+HYST exceeds value range");
  end

  localparam logic [N:0] UP_LOW   = (N+1)'(T_LOW + HYST);
  localparam logic [N:0] UP_HIGH  = (N+1)'(T_HIGH + HYST);
  localparam logic [N:0] DN_LOW   = (N+1)'(T_LOW - HYST);
  localparam logic [N:0] DN_HIGH  = (N+1)'(T_HIGH - HYST);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_TIMING = 1'b1;

  logic [N:0] value_x;
  logic [1:0] cand;
  logic [1:0] cand_reg;
  logic [0:0] state;
  logic       illegal;
  logic       cand_differs;
  logic       load;
  logic       restart;
  logic       done;
  logic       commit;

  assign value_x = {1'b0, value};

  // thresholds depend on where we are, giving each boundary a dead band
  always_comb begin
    cand = MOOD_NEUTRAL;
    case (mood)
      MOOD_SAD: begin
        if (value_x >= UP_HIGH)     cand = MOOD_HAPPY;
        else if (value_x >= UP_LOW) cand = MOOD_NEUTRAL;
        else                        cand = MOOD_SAD;
      end
      MOOD_NEUTRAL: begin
        if (value_x >= UP_HIGH)     cand = MOOD_HAPPY;
        else if (value_x <= DN_LOW) cand = MOOD_SAD;
        else                        cand = MOOD_NEUTRAL;
      end
      MOOD_HAPPY: begin
        if (value_x <= DN_LOW)       cand = MOOD_SAD;
        else if (value_x <= DN_HIGH) cand = MOOD_NEUTRAL;
        else                         cand = MOOD_HAPPY;
      end
      default: cand = MOOD_NEUTRAL;
    endcase
  end

  assign illegal      = (mood == 2'b11);
  assign cand_differs = (cand != mood);
  assign load         = cand_differs && !illegal &&
                        ((state == ST_IDLE) || (cand != cand_reg));
  assign restart      = !cand_differs || load || illegal;
  assign commit       = illegal || (cand_differs && !load && done);
  assign pending      = (state == ST_TIMING);

  dwell_timer #(
    .DWELL_W (DWELL_W),
    .DWELL   (DWELL)
  ) u_dwell_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick),
    .done    (done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mood         <= MOOD_NEUTRAL;
      cand_reg     <= MOOD_NEUTRAL;
      state        <= ST_IDLE;
      mood_changed <= 1'b0;
      mood_up      <= 1'b0;
    end else begin
      mood_changed <= 1'b0;
      if (commit) begin
        mood         <= cand;
        cand_reg     <= cand;
        state        <= ST_IDLE;
        mood_changed <= 1'b1;
        mood_up      <= (cand > mood);
      end else if (load) begin
        cand_reg <= cand;
        state    <= ST_TIMING;
      end else if (!cand_differs) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule
